// File: rtl/vliw_pkg.sv
// Shared VLIW pipeline types: MEM-stage FSM states, data-memory widths and the MEM/WB payload.
package vliw_pkg;

   localparam int unsigned DMEM_ADDR_W = 32;
   localparam int unsigned DMEM_DATA_W = 8;
   localparam int unsigned REG_IDX_W   = 3;
   localparam int unsigned WORD_W      = 32;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic                 alu_regwrite;
      logic                 mem_regwrite;
      logic [REG_IDX_W-1:0] alu_rd;
      logic [REG_IDX_W-1:0] mem_rd;
      logic [WORD_W-1:0]    alu_result;
      logic [WORD_W-1:0]    mem_load_data;
      logic                 flag_z;
      logic                 flag_n;
      logic                 flag_c;
      logic                 flag_v;
   } mem_wb_t;

   function automatic logic [WORD_W-1:0] ZERO_EXT8(input logic [7:0] b);
      return {24'b0, b};
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 8
);
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: capture on completion, bubble (regWrites cleared) on stall.
module mem_wb_reg
   import vliw_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    capture_i,
   input  logic    bubble_i,
   input  mem_wb_t wb_d_i,
   output mem_wb_t wb_o
);

   mem_wb_t wb_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_q <= '0;
      end else if (capture_i) begin
         wb_q <= wb_d_i;
      end else if (bubble_i) begin
         // Only the writeback enables are killed; data fields hold for forwarding stability.
         wb_q.alu_regwrite <= 1'b0;
         wb_q.mem_regwrite <= 1'b0;
      end
   end

   assign wb_o = wb_q;

endmodule

// File: rtl/mem_stage.sv
// VLIW memory stage: issues the EX/MEM byte load/store over req/ack, stalls while busy, feeds MEM/WB.
module mem_stage
   import vliw_pkg::*;
#(
   parameter int unsigned ADDR_W = DMEM_ADDR_W,
   parameter int unsigned DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p3_memRead,
   input  logic              p3_memWrite,
   input  logic              p3_alu_regWrite,
   input  logic              p3_mem_regWrite,
   input  logic [2:0]        p3_alu_rd,
   input  logic [2:0]        p3_mem_rd,
   input  logic [7:0]        p3_mem_reg_rd,
   input  logic [31:0]       p3_alu_aluOut,
   input  logic [ADDR_W-1:0] p3_mem_address,
   input  logic              p3_flag_z,
   input  logic              p3_flag_n,
   input  logic              p3_flag_c,
   input  logic              p3_flag_v,
   mem_stage_if.master       dmem,
   output logic              mem_stall,
   output logic              p4_alu_regWrite,
   output logic              p4_mem_regWrite,
   output logic [2:0]        p4_alu_rd,
   output logic [2:0]        p4_mem_rd,
   output logic [31:0]       p4_alu_result,
   output logic [31:0]       p4_mem_loadData,
   output logic              p4_flag_z,
   output logic              p4_flag_n,
   output logic              p4_flag_c,
   output logic              p4_flag_v
);

   mem_state_t state_q, state_d;
   logic       memop;
   logic       is_load;
   logic       req;
   logic       stall;
   mem_wb_t    wb_d, wb_q;

   assign memop   = p3_memRead | p3_memWrite;
   assign is_load = p3_memRead & ~p3_memWrite;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Request and stall depend only on state, memop and ack -- never on rdata.
   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      stall   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (memop) begin
               req = 1'b1;
               if (!dmem.dmem_ack) begin
                  stall   = 1'b1;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            req = 1'b1;
            if (dmem.dmem_ack) state_d = IDLE;
            else               stall   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = p3_memWrite;
   assign dmem.dmem_addr  = p3_mem_address;
   assign dmem.dmem_wdata = DATA_W'(p3_mem_reg_rd);
   assign mem_stall       = stall;

   always_comb begin
      wb_d               = '0;
      wb_d.alu_regwrite  = p3_alu_regWrite;
      wb_d.mem_regwrite  = p3_mem_regWrite & is_load;
      wb_d.alu_rd        = p3_alu_rd;
      wb_d.mem_rd        = p3_mem_rd;
      wb_d.alu_result    = p3_alu_aluOut;
      wb_d.mem_load_data = is_load ? ZERO_EXT8(8'(dmem.dmem_rdata)) : 32'h0;
      wb_d.flag_z        = p3_flag_z;
      wb_d.flag_n        = p3_flag_n;
      wb_d.flag_c        = p3_flag_c;
      wb_d.flag_v        = p3_flag_v;
   end

   mem_wb_reg u_mem_wb_reg (
      .clk       (clk),
      .reset     (reset),
      .capture_i (~stall),
      .bubble_i  (stall),
      .wb_d_i    (wb_d),
      .wb_o      (wb_q)
   );

   assign p4_alu_regWrite = wb_q.alu_regwrite;
   assign p4_mem_regWrite = wb_q.mem_regwrite;
   assign p4_alu_rd       = wb_q.alu_rd;
   assign p4_mem_rd       = wb_q.mem_rd;
   assign p4_alu_result   = wb_q.alu_result;
   assign p4_mem_loadData = wb_q.mem_load_data;
   assign p4_flag_z       = wb_q.flag_z;
   assign p4_flag_n       = wb_q.flag_n;
   assign p4_flag_c       = wb_q.flag_c;
   assign p4_flag_v       = wb_q.flag_v;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus stall, back-to-back and reset sequences.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        p3_memRead, p3_memWrite, p3_alu_regWrite, p3_mem_regWrite;
   logic [2:0]  p3_alu_rd, p3_mem_rd;
   logic [7:0]  p3_mem_reg_rd;
   logic [31:0] p3_alu_aluOut, p3_mem_address;
   logic        p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v;
   logic        mem_stall;
   logic        p4_alu_regWrite, p4_mem_regWrite;
   logic [2:0]  p4_alu_rd, p4_mem_rd;
   logic [31:0] p4_alu_result, p4_mem_loadData;
   logic        p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v;

   int checks = 0;
   int errors = 0;

   mem_stage_if #(.ADDR_W(32), .DATA_W(8)) dmem_bus ();

   mem_stage #(.ADDR_W(32), .DATA_W(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .p3_memRead      (p3_memRead),
      .p3_memWrite     (p3_memWrite),
      .p3_alu_regWrite (p3_alu_regWrite),
      .p3_mem_regWrite (p3_mem_regWrite),
      .p3_alu_rd       (p3_alu_rd),
      .p3_mem_rd       (p3_mem_rd),
      .p3_mem_reg_rd   (p3_mem_reg_rd),
      .p3_alu_aluOut   (p3_alu_aluOut),
      .p3_mem_address  (p3_mem_address),
      .p3_flag_z       (p3_flag_z),
      .p3_flag_n       (p3_flag_n),
      .p3_flag_c       (p3_flag_c),
      .p3_flag_v       (p3_flag_v),
      .dmem            (dmem_bus.master),
      .mem_stall       (mem_stall),
      .p4_alu_regWrite (p4_alu_regWrite),
      .p4_mem_regWrite (p4_mem_regWrite),
      .p4_alu_rd       (p4_alu_rd),
      .p4_mem_rd       (p4_mem_rd),
      .p4_alu_result   (p4_alu_result),
      .p4_mem_loadData (p4_mem_loadData),
      .p4_flag_z       (p4_flag_z),
      .p4_flag_n       (p4_flag_n),
      .p4_flag_c       (p4_flag_c),
      .p4_flag_v       (p4_flag_v)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        alu_we;
      logic [2:0]  alu_rd;
      logic [31:0] alu_out;
      logic        rd;
      logic        wr;
      logic        mem_we;
      logic [2:0]  mem_rd;
      logic [31:0] addr;
      logic [7:0]  wdata;
      logic [3:0]  flags;
      logic        ack;
      logic [7:0]  rdata;
      logic        e_req;
      logic        e_stall;
      logic        e_we;
      logic        e_alu_we;
      logic        e_mem_we;
      logic [2:0]  e_alu_rd;
      logic [2:0]  e_mem_rd;
      logic [31:0] e_res;
      logic [31:0] e_load;
      logic [3:0]  e_flags;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic alu_we, input logic [2:0] alu_rd, input logic [31:0] alu_out,
                        input logic rd, input logic wr, input logic mem_we, input logic [2:0] mem_rd,
                        input logic [31:0] addr, input logic [7:0] wdata, input logic [3:0] flags,
                        input logic ack, input logic [7:0] rdata);
      p3_alu_regWrite = alu_we;
      p3_alu_rd       = alu_rd;
      p3_alu_aluOut   = alu_out;
      p3_memRead      = rd;
      p3_memWrite     = wr;
      p3_mem_regWrite = mem_we;
      p3_mem_rd       = mem_rd;
      p3_mem_address  = addr;
      p3_mem_reg_rd   = wdata;
      {p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v} = flags;
      dmem_bus.dmem_ack   = ack;
      dmem_bus.dmem_rdata = rdata;
   endtask

   task automatic chk_p4(input string tag, input logic alu_we, input logic mem_we,
                         input logic [2:0] alu_rd, input logic [2:0] mem_rd,
                         input logic [31:0] res, input logic [31:0] load, input logic [3:0] flags);
      chk({tag, ".p4_alu_regWrite"}, 32'(p4_alu_regWrite), 32'(alu_we));
      chk({tag, ".p4_mem_regWrite"}, 32'(p4_mem_regWrite), 32'(mem_we));
      chk({tag, ".p4_alu_rd"},       32'(p4_alu_rd),       32'(alu_rd));
      chk({tag, ".p4_mem_rd"},       32'(p4_mem_rd),       32'(mem_rd));
      chk({tag, ".p4_alu_result"},   p4_alu_result,        res);
      chk({tag, ".p4_mem_loadData"}, p4_mem_loadData,      load);
      chk({tag, ".p4_flags"}, 32'({p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v}), 32'(flags));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[6];

   initial begin
      int stall_cnt;
      int done_cnt;

      // Fields: alu_we alu_rd alu_out rd wr mem_we mem_rd addr wdata flags ack rdata |
      //         e_req e_stall e_we e_alu_we e_mem_we e_alu_rd e_mem_rd e_res e_load e_flags
      vecs[0] = '{1'b1, 3'd5, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 8'h00, 4'h0, 1'b0, 8'h00,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 32'h0000_1234, 32'h0, 4'h0};
      vecs[1] = '{1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd3, 32'h40, 8'h00, 4'h0, 1'b1, 8'hA5,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 32'h0, 32'h0000_00A5, 4'h0};
      vecs[2] = '{1'b1, 3'd1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 3'd2, 32'h10, 8'h7E, 4'b1000, 1'b1, 8'hFF,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 3'd2, 32'hDEAD_BEEF, 32'h0, 4'b1000};
      vecs[3] = '{1'b1, 3'd7, 32'h0000_CAFE, 1'b0, 1'b0, 1'b1, 3'd6, 32'h0, 8'h00, 4'b0101, 1'b1, 8'h55,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 3'd6, 32'h0000_CAFE, 32'h0, 4'b0101};
      vecs[4] = '{1'b0, 3'd0, 32'h1, 1'b1, 1'b1, 1'b1, 3'd4, 32'h88, 8'h3C, 4'b0010, 1'b1, 8'h99,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 32'h1, 32'h0, 4'b0010};
      vecs[5] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 3'd7, 32'hFFFF_FFF0, 8'h00, 4'hF, 1'b1, 8'hFF,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd7, 32'hFFFF_FFFF, 32'h0000_00FF, 4'hF};

      reset = 1'b0;
      drive(1'b1, 3'd6, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 3'd6, 32'h0, 8'h0, 4'hF, 1'b0, 8'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset.req", 32'(dmem_bus.dmem_req), 32'h0);
      chk_p4("reset", 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 4'h0);
      reset = 1'b1;

      for (int i = 0; i < 6; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vecs[i].alu_we, vecs[i].alu_rd, vecs[i].alu_out, vecs[i].rd, vecs[i].wr, vecs[i].mem_we,
               vecs[i].mem_rd, vecs[i].addr, vecs[i].wdata, vecs[i].flags, vecs[i].ack, vecs[i].rdata);
         @(negedge clk);
         chk({tag, ".req"},   32'(dmem_bus.dmem_req), 32'(vecs[i].e_req));
         chk({tag, ".stall"}, 32'(mem_stall),         32'(vecs[i].e_stall));
         if (vecs[i].e_req) begin
            chk({tag, ".we"},    32'(dmem_bus.dmem_we),    32'(vecs[i].e_we));
            chk({tag, ".addr"},  dmem_bus.dmem_addr,       vecs[i].addr);
            chk({tag, ".wdata"}, 32'(dmem_bus.dmem_wdata), 32'(vecs[i].wdata));
         end
         next_cycle();
         chk_p4(tag, vecs[i].e_alu_we, vecs[i].e_mem_we, vecs[i].e_alu_rd, vecs[i].e_mem_rd,
                vecs[i].e_res, vecs[i].e_load, vecs[i].e_flags);
      end

      // Store 0x7E to 0x10, ack three cycles after issue.
      stall_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 3'd5, 32'h0000_0BAD, 1'b0, 1'b1, 1'b1, 3'd1, 32'h10, 8'h7E, 4'b0011,
               (c == 3), 8'hC3);
         @(negedge clk);
         chk($sformatf("st%0d.req", c),   32'(dmem_bus.dmem_req),   32'h1);
         chk($sformatf("st%0d.we", c),    32'(dmem_bus.dmem_we),    32'h1);
         chk($sformatf("st%0d.addr", c),  dmem_bus.dmem_addr,       32'h10);
         chk($sformatf("st%0d.wdata", c), 32'(dmem_bus.dmem_wdata), 32'h7E);
         chk($sformatf("st%0d.stall", c), 32'(mem_stall),           32'(c < 3));
         if (mem_stall) stall_cnt++;
         next_cycle();
         if (c < 3)
            chk_p4($sformatf("st%0d.bubble", c), 1'b0, 1'b0, 3'd2, 3'd7, 32'hFFFF_FFFF, 32'h0000_00FF, 4'hF);
         else
            chk_p4("st.done", 1'b1, 1'b0, 3'd5, 3'd1, 32'h0000_0BAD, 32'h0, 4'b0011);
      end
      chk("st.stall_cycles", 32'(stall_cnt), 32'd3);

      // Back-to-back loads, each acked one cycle after issue.
      stall_cnt = 0;
      done_cnt  = 0;
      for (int c = 0; c < 4; c++) begin
         if (c < 2) drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd1, 32'h20, 8'h0, 4'hF, (c == 1), 8'h11);
         else       drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd2, 32'h21, 8'h0, 4'hF, (c == 3), 8'h22);
         @(negedge clk);
         chk($sformatf("b2b%0d.req", c), 32'(dmem_bus.dmem_req), 32'h1);
         chk($sformatf("b2b%0d.stall", c), 32'(mem_stall), 32'(c == 0 || c == 2));
         if (mem_stall) stall_cnt++;
         if (dmem_bus.dmem_req && dmem_bus.dmem_ack) done_cnt++;
         next_cycle();
         if (c == 1) chk_p4("b2b.first", 1'b0, 1'b1, 3'd0, 3'd1, 32'h0, 32'h11, 4'hF);
         if (c == 2) chk("b2b.bubble.mem_we", 32'(p4_mem_regWrite), 32'h0);
         if (c == 3) chk_p4("b2b.second", 1'b0, 1'b1, 3'd0, 3'd2, 32'h0, 32'h22, 4'hF);
      end
      chk("b2b.stall_cycles", 32'(stall_cnt), 32'd2);
      chk("b2b.requests", 32'(done_cnt), 32'd2);

      // Reset asserted in the second WAIT cycle of a load.
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 3'd3, 32'h0000_7777, 1'b1, 1'b0, 1'b1, 3'd4, 32'h30, 8'h0, 4'h0, 1'b0, 8'h66);
         if (c == 2) reset = 1'b0;
         @(negedge clk);
         chk($sformatf("rst%0d.stall", c), 32'(mem_stall), 32'h1);
         next_cycle();
      end
      reset = 1'b1;
      drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 8'h0, 4'h0, 1'b0, 8'h0);
      chk_p4("rst.p4", 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("rst.req", 32'(dmem_bus.dmem_req), 32'h0);
      chk("rst.stall", 32'(mem_stall), 32'h0);
      next_cycle();

      // Stray ack after reset with an empty EX/MEM.
      drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 8'h0, 4'h0, 1'b1, 8'hEE);
      @(negedge clk);
      chk("stray.req", 32'(dmem_bus.dmem_req), 32'h0);
      chk("stray.stall", 32'(mem_stall), 32'h0);
      next_cycle();
      chk_p4("stray.p4", 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 4'h0);
      drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 8'h0, 4'h0, 1'b0, 8'h0);
      @(negedge clk);
      chk("stray.after.stall", 32'(mem_stall), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
